openhmc_axis_protocol_monitor: RTL and testbench
================================================

OPENHMC_AXIS_PROTOCOL_MONITOR -- requirements
Module: openhmc_axis_protocol_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of monitored AXI4-Stream channels (legal 1..8).
REQ-002 SHALL have parameter DWIDTH, default 512, TDATA width per channel.
REQ-003 SHALL have parameter NUM_DATA_BYTES, default 64, TUSER width per channel.
REQ-004 SHALL have parameter STALL_TIMEOUT_LOG, default 10, stall timeout of 2^STALL_TIMEOUT_LOG cycles.
REQ-005 SHALL have parameter ERR_CNT_WIDTH, default 16, violation counter width.
REQ-006 SHALL have port clk_hmc  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port res_hmc  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port mon_TVALID  input  NUM_CH  per-channel TVALID, channel c at bit c.
REQ-009 SHALL have port mon_TREADY  input  NUM_CH  per-channel TREADY.
REQ-010 SHALL have port mon_TDATA  input  NUM_CH*DWIDTH  per-channel TDATA, channel c at slice c.
REQ-011 SHALL have port mon_TUSER  input  NUM_CH*NUM_DATA_BYTES  per-channel TUSER.
REQ-012 SHALL have port clear_errors  input  1  synchronous clear of sticky flags and counter.
REQ-013 SHALL have port irq_mask  input  4  per-error-type enable for irq.
REQ-014 SHALL have port err_flags  output  NUM_CH*4  sticky flags per channel: bit0 VALID_DROP, bit1 DATA_CHANGE, bit2 USER_CHANGE, bit3 STALL_TIMEOUT.
REQ-015 SHALL have port err_count  output  ERR_CNT_WIDTH  saturating total violation count.
REQ-016 SHALL have port beat_count  output  NUM_CH*32  per-channel accepted-beat count.
REQ-017 SHALL have port irq  output  1  OR over channels of (err_flags & irq_mask).

Function
REQ-018 SHALL keep per-channel FSM states IDLE and PENDING; IDLE->PENDING when TVALID=1 and TREADY=0, capturing TDATA/TUSER into a snapshot.
REQ-019 SHALL, in PENDING: TVALID=0 -> VALID_DROP event, go IDLE; TVALID=1 and TREADY=1 -> go IDLE; else stay PENDING; snapshot unchanged while PENDING.
REQ-020 SHALL, in PENDING with TVALID=1, raise DATA_CHANGE if TDATA != snapshot and USER_CHANGE if TUSER != snapshot, including on the handshake cycle.
REQ-021 SHALL count consecutive PENDING cycles per channel, saturating; STALL_TIMEOUT event exactly once when count reaches 2^STALL_TIMEOUT_LOG-1; counter zeroed on leaving PENDING.
REQ-022 SHALL register every event into err_flags one cycle after the offending edge; flags sticky until clear_errors or reset.
REQ-023 SHALL add the popcount of all events across all channels in a cycle to err_count, saturating at all-ones, never wrapping.
REQ-024 SHALL increment beat_count[c] by 1 on each cycle with TVALID=1 and TREADY=1, wrapping 2^32-1 -> 0; unaffected by clear_errors.
REQ-025 SHALL on clear_errors with simultaneous events: set wins; flags = new events only, err_count = that cycle's popcount.
REQ-026 SHALL produce irq combinationally from registered err_flags and irq_mask.
REQ-027 SHALL not generate events on any channel in IDLE, regardless of TDATA/TUSER activity.

Reset
REQ-028 SHALL on res_hmc=1 force all FSMs to IDLE and zero err_flags, err_count, beat_count, stall counters and snapshots; irq=0.
REQ-029 SHALL discard a stall in progress when reset asserts; no event raised for it after reset releases.

Configuration
REQ-030 SHALL, with macro OPENHMC_AXIS_MON_TIMEOUT_EN defined, include stall counters and STALL_TIMEOUT detection.
REQ-031 SHALL, without OPENHMC_AXIS_MON_TIMEOUT_EN, omit stall counters; err_flags bit3 of every channel tied 0; STALL_TIMEOUT_LOG ignored.

Verification
REQ-032 SHALL cover ch0 TVALID=1, TREADY=0 for 3 cycles, then TVALID=0 -> err_flags[0]=1 next cycle, err_count=1, irq=1 with irq_mask=4'b0001.
REQ-033 SHALL cover ch1 stalled, TDATA changes 0xA5 -> 0x5A while TVALID=1 -> err_flags[5]=1, err_count=1; TUSER held -> err_flags[6]=0.
REQ-034 SHALL cover STALL_TIMEOUT_LOG=4, ch0 stalled 20 cycles -> err_flags[3] set once after 15th PENDING cycle, err_count=1 (macro defined); stays 0 with macro undefined.
REQ-035 SHALL cover both channels DATA_CHANGE+USER_CHANGE same cycle with ERR_CNT_WIDTH=2 -> err_count saturates at 3, never wraps.
REQ-036 SHALL cover clear_errors asserted in same cycle as ch0 VALID_DROP -> err_flags=only bit0, err_count=1; beat_count preserved.
REQ-037 SHALL cover res_hmc mid-stall, then TVALID held with TREADY=1 -> no events, beat_count[0] counts from 0.

Source files
------------

// File: rtl/openhmc_axis_protocol_monitor.sv
`default_nettype none
// ============================================================================
// Module   : openhmc_axis_protocol_monitor
// Purpose  : Passive AXI4-Stream rule checker for NUM_CH channels. Detects
//            TVALID withdrawn before handshake, TDATA/TUSER altered while a
//            beat is stalled, and (optionally) over-long stalls. Events are
//            latched into sticky per-channel flags, summed into a saturating
//            violation counter, and reduced to a maskable interrupt.
//            Accepted beats are counted per channel.
// Ports    : clk_hmc, res_hmc (sync, active-high)
//            mon_TVALID/TREADY [NUM_CH], mon_TDATA [NUM_CH*DWIDTH],
//            mon_TUSER [NUM_CH*NUM_DATA_BYTES], clear_errors, irq_mask[4]
//            err_flags [NUM_CH*4] {STALL_TIMEOUT,USER_CHANGE,DATA_CHANGE,
//            VALID_DROP}, err_count [ERR_CNT_WIDTH], beat_count [NUM_CH*32],
//            irq
// Config   : define OPENHMC_AXIS_MON_TIMEOUT_EN to build the stall counters
//            and STALL_TIMEOUT detection; otherwise flag bit3 is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module openhmc_axis_protocol_monitor #(
    parameter int NUM_CH            = 2,
    parameter int DWIDTH            = 512,
    parameter int NUM_DATA_BYTES    = 64,
    parameter int STALL_TIMEOUT_LOG = 10,
    parameter int ERR_CNT_WIDTH     = 16
) (
    input  logic                             clk_hmc,
    input  logic                             res_hmc,
    input  logic [NUM_CH-1:0]                mon_TVALID,
    input  logic [NUM_CH-1:0]                mon_TREADY,
    input  logic [NUM_CH*DWIDTH-1:0]         mon_TDATA,
    input  logic [NUM_CH*NUM_DATA_BYTES-1:0] mon_TUSER,
    input  logic                             clear_errors,
    input  logic [3:0]                       irq_mask,
    output logic [NUM_CH*4-1:0]              err_flags,
    output logic [ERR_CNT_WIDTH-1:0]         err_count,
    output logic [NUM_CH*32-1:0]             beat_count,
    output logic                             irq
);

    localparam logic [0:0] C_IDLE    = 1'b0;
    localparam logic [0:0] C_PENDING = 1'b1;
    localparam int         NUM_EV    = NUM_CH * 4;
    // Seven spare bits hold any per-cycle popcount (at most 32) without overflow.
    localparam int         SUM_W     = ERR_CNT_WIDTH + 7;
    localparam logic [SUM_W-1:0] C_CNT_MAX = {{7{1'b0}}, {ERR_CNT_WIDTH{1'b1}}};

    logic [NUM_EV-1:0]        w_events;
    logic [NUM_EV-1:0]        err_flags_q, err_flags_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic                      w_valid;
            logic                      w_ready;
            logic [DWIDTH-1:0]         w_data;
            logic [NUM_DATA_BYTES-1:0] w_user;
            logic [0:0]                state_q, state_d;
            logic [DWIDTH-1:0]         snap_data_q, snap_data_d;
            logic [NUM_DATA_BYTES-1:0] snap_user_q, snap_user_d;
            logic [31:0]               beat_q, beat_d;
            logic                      w_drop, w_dchg, w_uchg, w_tmo;

            assign w_valid = mon_TVALID[c];
            assign w_ready = mon_TREADY[c];
            assign w_data  = mon_TDATA[c*DWIDTH +: DWIDTH];
            assign w_user  = mon_TUSER[c*NUM_DATA_BYTES +: NUM_DATA_BYTES];

            always_comb begin
                state_d     = state_q;
                snap_data_d = snap_data_q;
                snap_user_d = snap_user_q;
                w_drop      = 1'b0;
                w_dchg      = 1'b0;
                w_uchg      = 1'b0;
                beat_d      = beat_q + ((w_valid && w_ready) ? 32'd1 : 32'd0);
                if (state_q == C_IDLE) begin
                    // Only a stalled beat is tracked; an immediate handshake stays IDLE.
                    if (w_valid && !w_ready) begin
                        state_d     = C_PENDING;
                        snap_data_d = w_data;
                        snap_user_d = w_user;
                    end
                end else begin
                    if (!w_valid) begin
                        w_drop  = 1'b1;
                        state_d = C_IDLE;
                    end else begin
                        // Payload must still match on the accepting cycle.
                        w_dchg = (w_data != snap_data_q);
                        w_uchg = (w_user != snap_user_q);
                        if (w_ready) begin
                            state_d = C_IDLE;
                        end
                    end
                end
            end

            always_ff @(posedge clk_hmc) begin
                if (res_hmc) begin
                    state_q     <= C_IDLE;
                    snap_data_q <= '0;
                    snap_user_q <= '0;
                    beat_q      <= '0;
                end else begin
                    state_q     <= state_d;
                    snap_data_q <= snap_data_d;
                    snap_user_q <= snap_user_d;
                    beat_q      <= beat_d;
                end
            end

`ifdef OPENHMC_AXIS_MON_TIMEOUT_EN
            localparam logic [STALL_TIMEOUT_LOG-1:0] C_STALL_MAX  = '1;
            localparam logic [STALL_TIMEOUT_LOG-1:0] C_STALL_TRIG = C_STALL_MAX - 1'b1;

            // stall_q holds the number of PENDING cycles already completed.
            logic [STALL_TIMEOUT_LOG-1:0] stall_q, stall_d;

            always_comb begin
                stall_d = '0;
                if ((state_q == C_PENDING) && (state_d == C_PENDING)) begin
                    stall_d = (stall_q == C_STALL_MAX) ? stall_q : stall_q + 1'b1;
                end
            end

            always_ff @(posedge clk_hmc) begin
                if (res_hmc) begin
                    stall_q <= '0;
                end else begin
                    stall_q <= stall_d;
                end
            end

            // The counter saturates at MAX, so it passes TRIG only once per stall.
            assign w_tmo = (state_q == C_PENDING) && (stall_q == C_STALL_TRIG);
`else
            assign w_tmo = 1'b0;
`endif

            assign w_events[c*4 +: 4]     = {w_tmo, w_uchg, w_dchg, w_drop};
            assign beat_count[c*32 +: 32] = beat_q;
        end
    endgenerate

    logic [6:0]       w_pop;
    logic [SUM_W-1:0] w_base;
    logic [SUM_W-1:0] w_sum;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_EV; i++) begin
            w_pop = w_pop + {6'd0, w_events[i]};
        end
        // A clear coinciding with new events keeps exactly those events.
        w_base      = clear_errors ? '0 : {7'd0, err_count_q};
        w_sum       = w_base + {{ERR_CNT_WIDTH{1'b0}}, w_pop};
        err_count_d = (w_sum > C_CNT_MAX) ? {ERR_CNT_WIDTH{1'b1}} : w_sum[ERR_CNT_WIDTH-1:0];
        err_flags_d = clear_errors ? w_events : (err_flags_q | w_events);
    end

    always_ff @(posedge clk_hmc) begin
        if (res_hmc) begin
            err_flags_q <= '0;
            err_count_q <= '0;
        end else begin
            err_flags_q <= err_flags_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_flags = err_flags_q;
    assign err_count = err_count_q;
    assign irq       = |(err_flags_q & {NUM_CH{irq_mask}});

endmodule
`default_nettype wire

// File: tb/tb_openhmc_axis_protocol_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_openhmc_axis_protocol_monitor
// Purpose  : Self-checking bench. A transaction-level model tracks, per
//            channel, whether a beat is outstanding, its payload and the stall
//            length, and derives flags/counts/irq every cycle. Directed
//            scenarios pin literal values; a random phase follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_openhmc_axis_protocol_monitor;

    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int UW  = 4;
    localparam int LOG = 4;
    localparam int EW  = 8;
    localparam int EWS = 2;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    tvalid;
    logic [NCH-1:0]    tready;
    logic [NCH*DW-1:0] tdata;
    logic [NCH*UW-1:0] tuser;
    logic              clr;
    logic [3:0]        mask;

    logic [NCH*4-1:0]  flags,  flags_s;
    logic [EW-1:0]     cnt;
    logic [EWS-1:0]    cnt_s;
    logic [NCH*32-1:0] beats,  beats_s;
    logic              irq,    irq_s;

    openhmc_axis_protocol_monitor #(
        .NUM_CH(NCH), .DWIDTH(DW), .NUM_DATA_BYTES(UW),
        .STALL_TIMEOUT_LOG(LOG), .ERR_CNT_WIDTH(EW)
    ) u_dut (
        .clk_hmc(clk), .res_hmc(rst), .mon_TVALID(tvalid), .mon_TREADY(tready),
        .mon_TDATA(tdata), .mon_TUSER(tuser), .clear_errors(clr), .irq_mask(mask),
        .err_flags(flags), .err_count(cnt), .beat_count(beats), .irq(irq)
    );

    openhmc_axis_protocol_monitor #(
        .NUM_CH(NCH), .DWIDTH(DW), .NUM_DATA_BYTES(UW),
        .STALL_TIMEOUT_LOG(LOG), .ERR_CNT_WIDTH(EWS)
    ) u_dut_sat (
        .clk_hmc(clk), .res_hmc(rst), .mon_TVALID(tvalid), .mon_TREADY(tready),
        .mon_TDATA(tdata), .mon_TUSER(tuser), .clear_errors(clr), .irq_mask(mask),
        .err_flags(flags_s), .err_count(cnt_s), .beat_count(beats_s), .irq(irq_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    bit          m_pend [NCH];
    logic [DW-1:0] m_sd [NCH];
    logic [UW-1:0] m_su [NCH];
    int          m_plen [NCH];
    logic [31:0] m_beat [NCH];
    logic [7:0]  m_flags;
    int          m_cnt;
    int          m_cnt_s;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step();
        logic [7:0] ev;
        int pop;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_pend[c] = 0; m_plen[c] = 0; m_beat[c] = '0;
                m_sd[c] = '0; m_su[c] = '0;
            end
            m_flags = '0; m_cnt = 0; m_cnt_s = 0;
            return;
        end
        ev = '0;
        for (int c = 0; c < NCH; c++) begin
            logic v;
            logic r;
            v = tvalid[c];
            r = tready[c];
            if (m_pend[c]) begin
                m_plen[c]++;
                if (!v) begin
                    ev[c*4] = 1'b1;
                end else begin
                    if (tdata[c*DW +: DW] != m_sd[c]) ev[c*4+1] = 1'b1;
                    if (tuser[c*UW +: UW] != m_su[c]) ev[c*4+2] = 1'b1;
                end
`ifdef OPENHMC_AXIS_MON_TIMEOUT_EN
                if (m_plen[c] == (1 << LOG) - 1) ev[c*4+3] = 1'b1;
`endif
                if (!v || r) begin
                    m_pend[c] = 0;
                    m_plen[c] = 0;
                end
            end else if (v && !r) begin
                m_pend[c] = 1;
                m_plen[c] = 0;
                m_sd[c]   = tdata[c*DW +: DW];
                m_su[c]   = tuser[c*UW +: UW];
            end
            if (v && r) m_beat[c] = m_beat[c] + 32'd1;
        end
        pop     = $countones(ev);
        m_flags = clr ? ev : (m_flags | ev);
        m_cnt   = sat((clr ? 0 : m_cnt) + pop, (1 << EW) - 1);
        m_cnt_s = sat((clr ? 0 : m_cnt_s) + pop, (1 << EWS) - 1);
    endtask

    // One compare process: model advances on each edge, outputs checked 1 later.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("flags",     {56'd0, flags},   {56'd0, m_flags});
            check("flags_sat", {56'd0, flags_s}, {56'd0, m_flags});
            check("count",     {56'd0, cnt},     64'(m_cnt));
            check("count_sat", {62'd0, cnt_s},   64'(m_cnt_s));
            check("beats",     beats,            {m_beat[1], m_beat[0]});
            check("irq",       {63'd0, irq},     {63'd0, |(m_flags & {NCH{mask}})});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; tvalid = '0; tready = '0; clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    int mode_r [NCH];
    int mode_v [NCH];

    initial begin
        rst = 1'b1; tvalid = '0; tready = '0; tdata = '0; tuser = '0;
        clr = 1'b0; mask = 4'b0001;

        // Reset state
        tick(); tick();
        check("rst_flags", {56'd0, flags}, 64'd0);
        check("rst_count", {56'd0, cnt},   64'd0);
        check("rst_beats", beats,          64'd0);
        check("rst_irq",   {63'd0, irq},   64'd0);
        rst = 1'b0;

        // Valid withdrawn after a 3-cycle stall on ch0
        tdata = 16'h0011; tvalid = 2'b01; tready = 2'b00;
        tick(); tick(); tick();
        check("drop_pre_flags", {56'd0, flags}, 64'h00);
        tvalid = 2'b00;
        tick();
        check("drop_flags", {56'd0, flags}, 64'h01);
        check("drop_count", {56'd0, cnt},   64'd1);
        check("drop_irq",   {63'd0, irq},   64'd1);

        // ch1 data altered on the accepting cycle, user held
        do_reset();
        tdata = 16'hA500; tuser = 8'h30; tvalid = 2'b10; tready = 2'b00;
        tick(); tick();
        tdata = 16'h5A00; tready = 2'b10;
        tick();
        check("dchg_flags", {56'd0, flags},    64'h20);
        check("dchg_count", {56'd0, cnt},      64'd1);
        check("dchg_uflag", {63'd0, flags[6]}, 64'd0);
        tvalid = 2'b00; tready = 2'b00;

        // Clear coinciding with a VALID_DROP; beats survive
        do_reset();
        tdata = '0; tuser = '0; tvalid = 2'b01; tready = 2'b01;
        tick(); tick();
        tvalid = 2'b11; tready = 2'b01;
        tick();
        tvalid = 2'b01; tready = 2'b00;
        tick();
        check("clr_pre_flags", {56'd0, flags}, 64'h10);
        check("clr_pre_count", {56'd0, cnt},   64'd1);
        tvalid = 2'b00; clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_flags", {56'd0, flags},  64'h01);
        check("clr_count", {56'd0, cnt},    64'd1);
        check("clr_beat0", {32'd0, beats[31:0]}, 64'd3);

        // Four simultaneous events into a 2-bit counter
        do_reset();
        tdata = 16'h0000; tuser = 8'h00; tvalid = 2'b11; tready = 2'b00;
        tick();
        tdata = 16'hFFFF; tuser = 8'hFF;
        tick();
        check("sat_flags", {56'd0, flags}, 64'h66);
        check("sat_count", {56'd0, cnt},   64'd4);
        check("sat_small", {62'd0, cnt_s}, 64'd3);
        tick();
        check("sat_small2", {62'd0, cnt_s}, 64'd3);
        tvalid = 2'b00;

        // 20-cycle stall on ch0: timeout after 15th PENDING cycle
        do_reset();
        tdata = '0; tuser = '0; tvalid = 2'b01; tready = 2'b00;
        for (int i = 1; i <= 20; i++) begin
            tick();
`ifdef OPENHMC_AXIS_MON_TIMEOUT_EN
            check("tmo_flag", {63'd0, flags[3]}, (i >= 16) ? 64'd1 : 64'd0);
`else
            check("tmo_flag", {63'd0, flags[3]}, 64'd0);
`endif
        end
`ifdef OPENHMC_AXIS_MON_TIMEOUT_EN
        check("tmo_count", {56'd0, cnt}, 64'd1);
`else
        check("tmo_count", {56'd0, cnt}, 64'd0);
`endif
        tvalid = 2'b00;
        tick();

        // Reset mid-stall, then continuous handshakes
        do_reset();
        tvalid = 2'b01; tready = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; tready = 2'b01;
        for (int i = 0; i < 20; i++) tick();
        check("rstmid_flags", {56'd0, flags}, 64'd0);
        check("rstmid_count", {56'd0, cnt},   64'd0);
        check("rstmid_beat0", {32'd0, beats[31:0]}, 64'd20);
        tvalid = 2'b00; tready = 2'b00;

        // Random phase
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (n % 150 == 0) begin
                    mode_r[c] = int'($urandom_range(0, 2));
                    mode_v[c] = int'($urandom_range(0, 1));
                end
                tvalid[c] = (mode_v[c] == 0) ? ($urandom_range(0, 7) != 0)
                                             : ($urandom_range(0, 31) != 0);
                case (mode_r[c])
                    0:       tready[c] = ($urandom_range(0, 1) != 0);
                    1:       tready[c] = ($urandom_range(0, 15) == 0);
                    default: tready[c] = ($urandom_range(0, 3) != 0);
                endcase
                if ($urandom_range(0, 5) == 0) tdata[c*DW +: DW] = 8'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) tuser[c*UW +: UW] = 4'($urandom_range(0, 1));
            end
            clr = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 99) == 0) mask = 4'($urandom_range(0, 15));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
